memory_map: RTL and testbench

// - Responder side of the CPU nibble-memory interface driven by regs (memory_addr/write_en/write_data/read_data).
// - Decodes the 12-bit nibble address into RAM, VRAM and an I/O register bank; returns registered read data.
// - Owns the interrupt factor/mask registers and a second, read-only VRAM port for the LCD scan-out.

---
 rtl/memory_map_pkg.sv | 51 +++++
 rtl/memory_map_io_regs.sv | 72 +++++++
 rtl/memory_map.sv | 147 ++++++++++++++
 tb/tb_memory_map.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_map_pkg.sv
// memory_map_pkg: shared address-map constants, region type and decode
// helpers for the nibble-memory responder (memory_map).
package memory_map_pkg;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_VRAM = 2'd1,
    REGION_IO   = 2'd2,
    REGION_NONE = 2'd3
  } mem_region_e;

  localparam logic [11:0] ADDR_VRAM0      = 12'hE00;
  localparam logic [11:0] ADDR_VRAM1      = 12'hE80;
  localparam int unsigned VRAM_LEN        = 80;
  localparam int unsigned VRAM_DEPTH      = 2 * VRAM_LEN;
  localparam logic [11:0] VRAM_LEN_A      = 12'd80;
  localparam logic [11:0] ADDR_IRQ_FACTOR = 12'hF00;
  localparam logic [11:0] ADDR_IRQ_MASK   = 12'hF10;
  localparam logic [11:0] ADDR_PREV_RST   = 12'hFFF;

  // Classify a CPU nibble address; ram_limit is the first address past RAM.
  function automatic mem_region_e decode_region(input logic [11:0] addr,
                                                input logic [11:0] ram_limit);
    mem_region_e region;
    if (addr < ram_limit) begin
      region = REGION_RAM;
    end else if ((addr >= ADDR_VRAM0) && (addr < (ADDR_VRAM0 + VRAM_LEN_A))) begin
      region = REGION_VRAM;
    end else if ((addr >= ADDR_VRAM1) && (addr < (ADDR_VRAM1 + VRAM_LEN_A))) begin
      region = REGION_VRAM;
    end else if ((addr == ADDR_IRQ_FACTOR) || (addr == ADDR_IRQ_MASK)) begin
      region = REGION_IO;
    end else begin
      region = REGION_NONE;
    end
    return region;
  endfunction

  // Fold the two 80-nibble VRAM windows into one linear 0..159 index.
  // Only meaningful when the address decodes as REGION_VRAM.
  function automatic logic [7:0] vram_index(input logic [11:0] addr);
    logic [7:0] idx;
    if (addr[7]) begin
      idx = {1'b0, addr[6:0]} + 8'd80;
    end else begin
      idx = {1'b0, addr[6:0]};
    end
    return idx;
  endfunction

endpackage

// File: rtl/memory_map_io_regs.sv
// memory_map_io_regs: interrupt factor (read-clear) and mask registers.
// The factor register clears on the first cycle of a read access to 0xF00;
// a set pulse arriving in that same cycle survives the clear. The read mux
// output is combinational; the parent registers it with the memory data.
module memory_map_io_regs
  import memory_map_pkg::*;
#(
  parameter int IRQ_FACTORS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [11:0]            addr,
  input  logic                   write_en,
  input  logic [IRQ_FACTORS-1:0] mask_wdata,
  input  logic [IRQ_FACTORS-1:0] factor_set,
  output logic [3:0]             rd_data,
  output logic                   irq_pending
);

  logic [IRQ_FACTORS-1:0] factor_d, factor_q;
  logic [IRQ_FACTORS-1:0] mask_d, mask_q;
  logic [11:0]            prev_addr_d, prev_addr_q;
  logic                   irq_pending_d, irq_pending_q;
  logic                   access_start_s;

  // Next-state for factor/mask and the pending flag derived from them.
  always_comb begin
    prev_addr_d    = addr;
    access_start_s = (addr == ADDR_IRQ_FACTOR) && (prev_addr_q != ADDR_IRQ_FACTOR) && !write_en;
    if (access_start_s) begin
      factor_d = factor_set;
    end else begin
      factor_d = factor_q | factor_set;
    end
    if (write_en && (addr == ADDR_IRQ_MASK)) begin
      mask_d = mask_wdata;
    end else begin
      mask_d = mask_q;
    end
    irq_pending_d = |(factor_d & mask_d);
  end

  // Read mux: the factor read returns the pre-clear snapshot (current q).
  always_comb begin
    rd_data = 4'h0;
    if (addr == ADDR_IRQ_FACTOR) begin
      rd_data[IRQ_FACTORS-1:0] = factor_q;
    end else if (addr == ADDR_IRQ_MASK) begin
      rd_data[IRQ_FACTORS-1:0] = mask_q;
    end else begin
      rd_data = 4'h0;
    end
  end

  // Register state; prev_addr resets to 0xFFF so the first 0xF00 read clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      factor_q      <= '0;
      mask_q        <= '0;
      prev_addr_q   <= ADDR_PREV_RST;
      irq_pending_q <= 1'b0;
    end else begin
      factor_q      <= factor_d;
      mask_q        <= mask_d;
      prev_addr_q   <= prev_addr_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq_pending = irq_pending_q;

endmodule

// File: rtl/memory_map.sv
// memory_map: responder for the CPU nibble-memory port. Decodes RAM, VRAM
// and the interrupt I/O bank, returns 1-cycle registered read data, and
// exposes a read-only VRAM port for LCD scan-out.
// Optional feature macro: UNMAPPED_TRAP_EN (sticky unmapped-access capture).
module memory_map
  import memory_map_pkg::*;
#(
  parameter int RAM_DEPTH   = 640,
  parameter int IRQ_FACTORS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [11:0]            memory_addr,
  input  logic                   memory_write_en,
  input  logic [3:0]             memory_write_data,
  output logic [3:0]             memory_read_data,
  input  logic [IRQ_FACTORS-1:0] irq_factor_set,
  output logic                   irq_pending,
  input  logic [7:0]             video_addr,
  output logic [3:0]             video_data,
  output logic                   unmapped_err,
  output logic [11:0]            unmapped_addr
);

  localparam int          RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [11:0] RAM_LIMIT = 12'(RAM_DEPTH);

  // Storage is not reset; contents persist across reset.
  logic [3:0] ram_mem  [RAM_DEPTH];
  logic [3:0] vram_mem [VRAM_DEPTH];

  mem_region_e       region_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic [7:0]        vram_idx_s;
  logic              ram_we_s, vram_we_s;
  logic [3:0]        io_rd_data_s;
  logic [3:0]        rd_data_d, rd_data_q;
  logic [3:0]        video_data_d, video_data_q;

  memory_map_io_regs #(
    .IRQ_FACTORS(IRQ_FACTORS)
  ) u_io_regs (
    .clk        (clk),
    .reset      (reset),
    .addr       (memory_addr),
    .write_en   (memory_write_en),
    .mask_wdata (memory_write_data[IRQ_FACTORS-1:0]),
    .factor_set (irq_factor_set),
    .rd_data    (io_rd_data_s),
    .irq_pending(irq_pending)
  );

  // Address decode and per-region write enables.
  always_comb begin
    region_s   = decode_region(memory_addr, RAM_LIMIT);
    ram_idx_s  = memory_addr[RAM_AW-1:0];
    vram_idx_s = vram_index(memory_addr);
    ram_we_s   = memory_write_en && (region_s == REGION_RAM);
    vram_we_s  = memory_write_en && (region_s == REGION_VRAM);
  end

  // CPU read mux; unmapped addresses read as zero.
  always_comb begin
    case (region_s)
      REGION_RAM:  rd_data_d = ram_mem[ram_idx_s];
      REGION_VRAM: rd_data_d = vram_mem[vram_idx_s];
      REGION_IO:   rd_data_d = io_rd_data_s;
      default:     rd_data_d = 4'h0;
    endcase
  end

  // Video read: indices past the 160-nibble VRAM read as zero.
  always_comb begin
    if (video_addr < 8'(VRAM_DEPTH)) begin
      video_data_d = vram_mem[video_addr];
    end else begin
      video_data_d = 4'h0;
    end
  end

  // RAM write port (reads happen via the registered mux, so read-first).
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_mem[ram_idx_s] <= memory_write_data;
    end
  end

  // VRAM CPU write port; the video port only reads.
  always_ff @(posedge clk) begin
    if (vram_we_s) begin
      vram_mem[vram_idx_s] <= memory_write_data;
    end
  end

  // Output data registers: one cycle of latency on both ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q    <= 4'h0;
      video_data_q <= 4'h0;
    end else begin
      rd_data_q    <= rd_data_d;
      video_data_q <= video_data_d;
    end
  end

  assign memory_read_data = rd_data_q;
  assign video_data       = video_data_q;

`ifdef UNMAPPED_TRAP_EN
  logic        unmapped_err_d, unmapped_err_q;
  logic [11:0] unmapped_addr_d, unmapped_addr_q;

  // Sticky error flag; the address is captured only on the first offence.
  always_comb begin
    unmapped_err_d  = unmapped_err_q;
    unmapped_addr_d = unmapped_addr_q;
    if (region_s == REGION_NONE) begin
      unmapped_err_d = 1'b1;
      if (!unmapped_err_q) begin
        unmapped_addr_d = memory_addr;
      end else begin
        unmapped_addr_d = unmapped_addr_q;
      end
    end else begin
      unmapped_err_d = unmapped_err_q;
    end
  end

  // Trap capture registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      unmapped_err_q  <= 1'b0;
      unmapped_addr_q <= 12'h000;
    end else begin
      unmapped_err_q  <= unmapped_err_d;
      unmapped_addr_q <= unmapped_addr_d;
    end
  end

  assign unmapped_err  = unmapped_err_q;
  assign unmapped_addr = unmapped_addr_q;
`else
  assign unmapped_err  = 1'b0;
  assign unmapped_addr = 12'h000;
`endif

endmodule

// File: tb/tb_memory_map.sv
// tb_memory_map: directed vector table, hand-written reset/read-clear
// sequences and randomized traffic checked against a behavioural model.
module tb_memory_map;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] memory_addr;
  logic        memory_write_en;
  logic [3:0]  memory_write_data;
  logic [3:0]  memory_read_data;
  logic [3:0]  irq_factor_set;
  logic        irq_pending;
  logic [7:0]  video_addr;
  logic [3:0]  video_data;
  logic        unmapped_err;
  logic [11:0] unmapped_addr;

  always #5 clk = ~clk;

  memory_map dut (
    .clk              (clk),
    .reset            (reset),
    .memory_addr      (memory_addr),
    .memory_write_en  (memory_write_en),
    .memory_write_data(memory_write_data),
    .memory_read_data (memory_read_data),
    .irq_factor_set   (irq_factor_set),
    .irq_pending      (irq_pending),
    .video_addr       (video_addr),
    .video_data       (video_data),
    .unmapped_err     (unmapped_err),
    .unmapped_addr    (unmapped_addr)
  );

`ifdef UNMAPPED_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state
  logic [3:0]  m_ram  [640];
  logic [3:0]  m_vram [160];
  logic [3:0]  m_factor, m_mask, m_rd, m_vd;
  logic [11:0] m_prev, m_eaddr;
  logic        m_irq, m_err;

  typedef struct {
    logic [11:0] a;
    logic        we;
    logic [3:0]  wd;
    logic [3:0]  set;
    logic [7:0]  va;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_vd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock of the specified behaviour, evaluated from the pre-edge state.
  task automatic model_step(input logic rst, input logic [11:0] a, input logic we,
                            input logic [3:0] wd, input logic [3:0] set, input logic [7:0] va);
    int  ai, vi;
    bit  is_ram, is_vram, start, unm;
    if (rst) begin
      m_rd = 4'h0; m_vd = 4'h0; m_factor = 4'h0; m_mask = 4'h0; m_irq = 1'b0;
      m_err = 1'b0; m_eaddr = 12'h000; m_prev = 12'hFFF;
      return;
    end
    ai = int'(a);
    vi = -1;
    is_ram = (ai < 640);
    if (ai >= 32'hE00 && ai < 32'hE00 + 80) vi = ai - 32'hE00;
    else if (ai >= 32'hE80 && ai < 32'hE80 + 80) vi = ai - 32'hE80 + 80;
    is_vram = (vi >= 0);
    unm = !is_ram && !is_vram && (ai != 32'hF00) && (ai != 32'hF10);
    if (is_ram) m_rd = m_ram[ai];
    else if (is_vram) m_rd = m_vram[vi];
    else if (ai == 32'hF00) m_rd = m_factor;
    else if (ai == 32'hF10) m_rd = m_mask;
    else m_rd = 4'h0;
    m_vd = (va < 8'd160) ? m_vram[va] : 4'h0;
    start = (ai == 32'hF00) && (m_prev != 12'hF00) && !we;
    if (we) begin
      if (is_ram) m_ram[ai] = wd;
      else if (is_vram) m_vram[vi] = wd;
      else if (ai == 32'hF10) m_mask = wd;
    end
    if (start) m_factor = 4'h0;
    m_factor = m_factor | set;
    m_irq = |(m_factor & m_mask);
    if (TRAP_ON && unm) begin
      if (!m_err) m_eaddr = a;
      m_err = 1'b1;
    end
    m_prev = a;
  endtask

  // Drive one cycle, advance the model, and compare every output with it.
  task automatic cycle(input bit chk, input logic rst, input logic [11:0] a, input logic we,
                       input logic [3:0] wd, input logic [3:0] set, input logic [7:0] va);
    reset = rst; memory_addr = a; memory_write_en = we; memory_write_data = wd;
    irq_factor_set = set; video_addr = va;
    model_step(rst, a, we, wd, set, va);
    @(posedge clk);
    #1;
    if (chk) begin
      check("model_read_data", {8'h00, memory_read_data}, {8'h00, m_rd});
      check("model_video_data", {8'h00, video_data}, {8'h00, m_vd});
      check("model_irq_pending", {11'h000, irq_pending}, {11'h000, m_irq});
      check("model_unmapped_err", {11'h000, unmapped_err}, {11'h000, m_err});
      check("model_unmapped_addr", unmapped_addr, m_eaddr);
    end
  endtask

  initial begin
    logic [11:0] ra, last_a;
    logic        rwe, rrst;
    logic [11:0] edge_addrs [8];
    int          sel;

    for (int i = 0; i < 640; i++) m_ram[i] = 4'h0;
    for (int i = 0; i < 160; i++) m_vram[i] = 4'h0;
    edge_addrs = '{12'd639, 12'd640, 12'hE4F, 12'hE50, 12'hE7F, 12'hECF, 12'hED0, 12'hF00};

    //            a        we    wd    set   va      rd    vd    irq
    vecs[0]  = '{12'h123, 1'b1, 4'hA, 4'h0, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[1]  = '{12'h123, 1'b0, 4'h0, 4'h0, 8'd0,   4'hA, 4'h0, 1'b0};
    vecs[2]  = '{12'hE81, 1'b1, 4'h5, 4'h0, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[3]  = '{12'h000, 1'b0, 4'h0, 4'h0, 8'd81,  4'h0, 4'h5, 1'b0};
    vecs[4]  = '{12'h000, 1'b0, 4'h0, 4'h0, 8'd200, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{12'hE81, 1'b0, 4'h0, 4'h0, 8'd81,  4'h5, 4'h5, 1'b0};
    vecs[6]  = '{12'h300, 1'b0, 4'h0, 4'h0, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[7]  = '{12'hD00, 1'b0, 4'h0, 4'h0, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[8]  = '{12'h000, 1'b0, 4'h0, 4'h5, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[9]  = '{12'hF10, 1'b1, 4'h4, 4'h0, 8'd0,   4'h0, 4'h0, 1'b1};
    vecs[10] = '{12'hF00, 1'b0, 4'h0, 4'h0, 8'd0,   4'h5, 4'h0, 1'b0};
    vecs[11] = '{12'hF00, 1'b0, 4'h0, 4'h0, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[12] = '{12'hF10, 1'b0, 4'h0, 4'h0, 8'd0,   4'h4, 4'h0, 1'b0};
    vecs[13] = '{12'hF00, 1'b0, 4'h0, 4'h2, 8'd0,   4'h0, 4'h0, 1'b0};
    vecs[14] = '{12'hF00, 1'b0, 4'h0, 4'h0, 8'd0,   4'h2, 4'h0, 1'b0};
    vecs[15] = '{12'hE81, 1'b1, 4'h9, 4'h0, 8'd81,  4'h5, 4'h5, 1'b0};
    vecs[16] = '{12'h000, 1'b0, 4'h0, 4'h0, 8'd81,  4'h0, 4'h9, 1'b0};

    // Reset: outputs must come up zero.
    cycle(1'b1, 1'b1, 12'h000, 1'b0, 4'h0, 4'h0, 8'd0);
    cycle(1'b1, 1'b1, 12'h000, 1'b0, 4'h0, 4'h0, 8'd0);
    check("reset_read_data", {8'h00, memory_read_data}, 12'h000);
    check("reset_irq_pending", {11'h000, irq_pending}, 12'h000);

    // Bring every RAM/VRAM cell to a known zero.
    for (int i = 0; i < 640; i++) cycle(1'b0, 1'b0, 12'(i), 1'b1, 4'h0, 4'h0, 8'd0);
    for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0, 12'hE00 + 12'(i), 1'b1, 4'h0, 4'h0, 8'd0);
    for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0, 12'hE80 + 12'(i), 1'b1, 4'h0, 4'h0, 8'd0);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b0, vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].set, vecs[i].va);
      check($sformatf("vec%0d_read_data", i), {8'h00, memory_read_data}, {8'h00, vecs[i].exp_rd});
      check($sformatf("vec%0d_video_data", i), {8'h00, video_data}, {8'h00, vecs[i].exp_vd});
      check($sformatf("vec%0d_irq_pending", i), {11'h000, irq_pending}, {11'h000, vecs[i].exp_irq});
    end
    check("trap_err_after_unmapped", {11'h000, unmapped_err}, TRAP_ON ? 12'h001 : 12'h000);
    check("trap_first_addr", unmapped_addr, TRAP_ON ? 12'h300 : 12'h000);

    // Reset in the middle of activity with factor=0xF and mask=0xF.
    cycle(1'b1, 1'b0, 12'h000, 1'b0, 4'h0, 4'hF, 8'd81);
    cycle(1'b1, 1'b0, 12'hF10, 1'b1, 4'hF, 4'h0, 8'd81);
    check("pre_reset_irq", {11'h000, irq_pending}, 12'h001);
    cycle(1'b1, 1'b1, 12'h123, 1'b0, 4'h0, 4'h0, 8'd81);
    check("mid_reset_read_data", {8'h00, memory_read_data}, 12'h000);
    check("mid_reset_video_data", {8'h00, video_data}, 12'h000);
    check("mid_reset_irq", {11'h000, irq_pending}, 12'h000);
    check("mid_reset_err", {11'h000, unmapped_err}, 12'h000);
    check("mid_reset_eaddr", unmapped_addr, 12'h000);
    cycle(1'b1, 1'b0, 12'h123, 1'b0, 4'h0, 4'h0, 8'd81);
    check("ram_survives_reset", {8'h00, memory_read_data}, 12'h00A);
    check("video_survives_reset", {8'h00, video_data}, 12'h009);
    cycle(1'b1, 1'b0, 12'hF00, 1'b0, 4'h0, 4'h0, 8'd0);
    check("factor_cleared_by_reset", {8'h00, memory_read_data}, 12'h000);
    cycle(1'b1, 1'b0, 12'hF10, 1'b0, 4'h0, 4'h0, 8'd0);
    check("mask_cleared_by_reset", {8'h00, memory_read_data}, 12'h000);

    // Randomized traffic against the model.
    last_a = 12'h000;
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0, 1, 2: ra = 12'($urandom_range(0, 639));
        3:       ra = ($urandom_range(0, 1) == 0) ? 12'hE00 + 12'($urandom_range(0, 79))
                                                  : 12'hE80 + 12'($urandom_range(0, 79));
        4:       ra = 12'hF00;
        5:       ra = 12'hF10;
        6:       ra = 12'($urandom_range(0, 4095));
        7:       ra = edge_addrs[$urandom_range(0, 7)];
        default: ra = last_a;
      endcase
      rrst = ($urandom_range(0, 299) == 0);
      rwe  = !rrst && ($urandom_range(0, 3) == 0);
      cycle(1'b1, rrst, ra, rwe, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            8'($urandom_range(0, 255)));
      last_a = ra;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
